// File: rtl/segment_capture_sequencer.sv
// rtl/segment_capture_sequencer.sv - multi-segment ADC capture sequencer around trigger_unit
// Optional ARMED-state timeout is built when SEG_TIMEOUT_EN is defined.
module segment_capture_sequencer #(
    parameter int SEG_W  = 16,
    parameter int SAMP_W = 32,
    parameter int CYC_W  = 20
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              cmd_arm,
    input  logic [SEG_W-1:0]  num_segments,
    input  logic [SAMP_W-1:0] segment_samples,
    input  logic [CYC_W-1:0]  segment_cycles,
    input  logic [31:0]       timeout_cycles,
    input  logic              capture_go_i,
    input  logic              fifo_full_i,
    output logic              arm_o,
    output logic              capture_done_o,
    output logic              fifo_wr_o,
    output logic [SEG_W-1:0]  seg_index_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic              missed_trig_o,
    output logic              timeout_o,
    output logic [2:0]        state_o
);

    localparam int CMP_W = (CYC_W > SAMP_W) ? CYC_W : SAMP_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_arm_q, cmd_arm_d;
    logic [SAMP_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [SEG_W-1:0]   seg_index_q, seg_index_d;
    logic               arm_q, arm_d;
    logic               capture_done_q, capture_done_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               missed_q, missed_d;
    logic               timeout_q, timeout_d;

    logic [SAMP_W-1:0]  eff_samples, last_samp;
    logic [SEG_W-1:0]   eff_segments;
    logic [CYC_W-1:0]   last_cyc;
    logic               arm_rise, seg_last, back_to_back, tmo_hit;

    assign eff_samples  = (segment_samples == '0) ? SAMP_W'(1) : segment_samples;
    assign last_samp    = eff_samples - SAMP_W'(1);
    assign eff_segments = (num_segments == '0) ? SEG_W'(1) : num_segments;
    assign last_cyc     = segment_cycles - CYC_W'(1);
    assign seg_last     = (seg_index_q + SEG_W'(1)) == eff_segments;
    // A period no longer than the burst leaves no gap: segments run back to back.
    assign back_to_back = CMP_W'(segment_cycles) <= CMP_W'(eff_samples);
    // cmd_arm_q resets high so a level already high out of reset is not an edge.
    assign arm_rise     = cmd_arm && !cmd_arm_q;
    assign cmd_arm_d    = cmd_arm;

`ifdef SEG_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = (state_q == S_ARMED) ? tmo_cnt_q + 32'd1 : 32'd0;
    assign tmo_hit   = (timeout_cycles != '0) && ((tmo_cnt_q + 32'd1) == timeout_cycles);

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        samp_cnt_d     = samp_cnt_q;
        cyc_cnt_d      = cyc_cnt_q;
        seg_index_d    = seg_index_q;
        arm_d          = 1'b0;
        capture_done_d = 1'b0;
        fifo_wr_d      = 1'b0;
        done_d         = 1'b0;
        overflow_d     = overflow_q;
        missed_d       = missed_q;
        timeout_d      = timeout_q;

        if ((state_q == S_CAPTURE || state_q == S_GAP) && capture_go_i) missed_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (arm_rise) begin
                    state_d     = S_ARMED;
                    arm_d       = 1'b1;
                    seg_index_d = '0;
                    overflow_d  = 1'b0;
                    missed_d    = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            S_ARMED: begin
                arm_d = 1'b1;
                if (!cmd_arm) begin
                    state_d = S_IDLE;
                    arm_d   = 1'b0;
                end else if (capture_go_i) begin
                    state_d    = S_CAPTURE;
                    samp_cnt_d = '0;
                    cyc_cnt_d  = '0;
                    fifo_wr_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d        = S_DONE;
                    arm_d          = 1'b0;
                    capture_done_d = 1'b1;
                    done_d         = 1'b1;
                    timeout_d      = 1'b1;
                end
            end
            S_CAPTURE: begin
                arm_d      = 1'b1;
                samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                cyc_cnt_d  = cyc_cnt_q + CYC_W'(1);
                if (!cmd_arm) begin
                    state_d = S_IDLE;
                    arm_d   = 1'b0;
                end else if (fifo_full_i) begin
                    state_d        = S_DONE;
                    arm_d          = 1'b0;
                    capture_done_d = 1'b1;
                    done_d         = 1'b1;
                    overflow_d     = 1'b1;
                end else if (samp_cnt_q == last_samp) begin
                    seg_index_d = seg_index_q + SEG_W'(1);
                    if (seg_last) begin
                        state_d        = S_DONE;
                        arm_d          = 1'b0;
                        capture_done_d = 1'b1;
                        done_d         = 1'b1;
                    end else if (segment_cycles == '0) begin
                        state_d = S_ARMED;
                    end else if (back_to_back) begin
                        samp_cnt_d = '0;
                        cyc_cnt_d  = '0;
                        fifo_wr_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    fifo_wr_d = 1'b1;
                end
            end
            S_GAP: begin
                arm_d     = 1'b1;
                cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                if (!cmd_arm) begin
                    state_d = S_IDLE;
                    arm_d   = 1'b0;
                end else if (cyc_cnt_q == last_cyc) begin
                    state_d    = S_CAPTURE;
                    samp_cnt_d = '0;
                    cyc_cnt_d  = '0;
                    fifo_wr_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (!cmd_arm) state_d = S_IDLE;
                else          done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cmd_arm_q      <= 1'b1;
            samp_cnt_q     <= '0;
            cyc_cnt_q      <= '0;
            seg_index_q    <= '0;
            arm_q          <= 1'b0;
            capture_done_q <= 1'b0;
            fifo_wr_q      <= 1'b0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            missed_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_arm_q      <= cmd_arm_d;
            samp_cnt_q     <= samp_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            seg_index_q    <= seg_index_d;
            arm_q          <= arm_d;
            capture_done_q <= capture_done_d;
            fifo_wr_q      <= fifo_wr_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            missed_q       <= missed_d;
            timeout_q      <= timeout_d;
        end
    end

    assign arm_o          = arm_q;
    assign capture_done_o = capture_done_q;
    assign fifo_wr_o      = fifo_wr_q;
    assign seg_index_o    = seg_index_q;
    assign done_o         = done_q;
    assign overflow_o     = overflow_q;
    assign missed_trig_o  = missed_q;
    assign timeout_o      = timeout_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_segment_capture_sequencer.sv
// tb/tb_segment_capture_sequencer.sv - scoreboard bench for segment_capture_sequencer
module tb_segment_capture_sequencer;

    logic        adc_clk = 1'b0;
    logic        reset_n;
    logic        cmd_arm;
    logic [15:0] num_segments;
    logic [31:0] segment_samples;
    logic [19:0] segment_cycles;
    logic [31:0] timeout_cycles;
    logic        capture_go_i;
    logic        fifo_full_i;
    logic        arm_o, capture_done_o, fifo_wr_o, done_o;
    logic        overflow_o, missed_trig_o, timeout_o;
    logic [15:0] seg_index_o;
    logic [2:0]  state_o;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int exp_wr[$];
    int exp_done[$];

    segment_capture_sequencer dut (
        .adc_clk        (adc_clk),
        .reset_n        (reset_n),
        .cmd_arm        (cmd_arm),
        .num_segments   (num_segments),
        .segment_samples(segment_samples),
        .segment_cycles (segment_cycles),
        .timeout_cycles (timeout_cycles),
        .capture_go_i   (capture_go_i),
        .fifo_full_i    (fifo_full_i),
        .arm_o          (arm_o),
        .capture_done_o (capture_done_o),
        .fifo_wr_o      (fifo_wr_o),
        .seg_index_o    (seg_index_o),
        .done_o         (done_o),
        .overflow_o     (overflow_o),
        .missed_trig_o  (missed_trig_o),
        .timeout_o      (timeout_o),
        .state_o        (state_o)
    );

    always #5 adc_clk = ~adc_clk;
    always @(posedge adc_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe / done pulse must match the next expected cycle.
    always @(negedge adc_clk) begin
        if (fifo_wr_o) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_wr: strobe at cycle %0d, expected none", cyc);
            end else begin
                check("wr_cycle", cyc, exp_wr.pop_front());
            end
        end
        if (capture_done_o) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: pulse at cycle %0d, expected none", cyc);
            end else begin
                check("done_cycle", cyc, exp_done.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic pulse_go();
        capture_go_i = 1'b1;
        tick(1);
        capture_go_i = 1'b0;
    endtask

    task automatic arm_seq();
        cmd_arm = 1'b1;
        tick(1);
        check("arm_o", arm_o, 1);
        check("armed_state", state_o, 1);
        check("sticky_clear", {overflow_o, missed_trig_o, timeout_o}, 0);
    endtask

    task automatic release_arm();
        cmd_arm = 1'b0;
        tick(1);
        check("idle_state", state_o, 0);
        check("done_cleared", done_o, 0);
        tick(1);
    endtask

    // Reference model: burst b starts at trigger+1+b*max(period,samples) in
    // time-spaced mode, or at its own trigger+1 in trigger-spaced mode.
    task automatic do_capture(input int n_raw, input int s_raw, input int p,
                              input int pre, input int gap, input bit inj);
        int n, s, t, span, done_at, g;
        bit exp_missed;
        n = (n_raw == 0) ? 1 : n_raw;
        s = (s_raw == 0) ? 1 : s_raw;
        exp_missed = 1'b0;
        num_segments    = 16'(n_raw);
        segment_samples = 32'(s_raw);
        segment_cycles  = 20'(p);
        arm_seq();
        tick(pre - 1);
        if (p != 0) begin
            span = (p > s) ? p : s;
            t = cyc;
            for (int b = 0; b < n; b++)
                for (int i = 0; i < s; i++) exp_wr.push_back(t + 1 + b * span + i);
            done_at = t + (n - 1) * span + s + 1;
            exp_done.push_back(done_at);
            pulse_go();
            if (inj && n > 1 && p > s) begin
                tick(s);
                pulse_go();
                exp_missed = 1'b1;
                check("missed_in_gap", missed_trig_o, 1);
            end
        end else begin
            done_at = 0;
            for (int b = 0; b < n; b++) begin
                t = cyc;
                for (int i = 0; i < s; i++) exp_wr.push_back(t + 1 + i);
                if (b == n - 1) begin
                    done_at = t + s + 1;
                    exp_done.push_back(done_at);
                end
                pulse_go();
                if (b != n - 1) begin
                    g = (gap == 0) ? s + $urandom_range(0, 4) : gap - 1;
                    tick(g);
                    check("arm_between_segs", arm_o, 1);
                end
            end
        end
        while (cyc < done_at + 1) tick(1);
        check("wr_drained", exp_wr.size(), 0);
        check("done_drained", exp_done.size(), 0);
        check("done_o", done_o, 1);
        check("arm_dropped", arm_o, 0);
        check("seg_index", seg_index_o, n);
        check("missed_trig", missed_trig_o, exp_missed);
        check("overflow_clear", overflow_o, 0);
        release_arm();
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        cmd_arm = 1'b1;
        num_segments = 16'd1;
        segment_samples = 32'd8;
        segment_cycles = 20'd0;
        timeout_cycles = 32'd0;
        capture_go_i = 1'b0;
        fifo_full_i = 1'b0;
        #23;
        check("reset_outputs", {arm_o, capture_done_o, fifo_wr_o, done_o, overflow_o,
                                missed_trig_o, timeout_o, state_o, seg_index_o}, 0);
        @(posedge adc_clk);
        #1;
        reset_n = 1'b1;
        tick(5);
        check("held_arm_no_start", state_o, 0);
        check("held_arm_no_arm_o", arm_o, 0);
        cmd_arm = 1'b0;
        tick(2);

        // Directed: single segment, trigger-spaced, time-spaced with missed trigger.
        do_capture(1, 8, 0, 5, 0, 1'b0);
        do_capture(3, 4, 0, 3, 20, 1'b0);
        do_capture(4, 5, 12, 2, 0, 1'b1);

        // Overflow on the third sample of the first segment.
        num_segments = 16'd2;
        segment_samples = 32'd6;
        segment_cycles = 20'd0;
        arm_seq();
        tick(2);
        t = cyc;
        exp_wr.push_back(t + 1);
        exp_wr.push_back(t + 2);
        exp_done.push_back(t + 3);
        pulse_go();
        tick(1);
        fifo_full_i = 1'b1;
        tick(1);
        fifo_full_i = 1'b0;
        check("ovf_flag", overflow_o, 1);
        check("ovf_state", state_o, 4);
        check("ovf_no_strobe", fifo_wr_o, 0);
        check("ovf_seg_index", seg_index_o, 0);
        tick(1);
        check("ovf_wr_drained", exp_wr.size(), 0);
        release_arm();
        check("ovf_sticky", overflow_o, 1);

        // Abort mid-capture of the second segment.
        arm_seq();
        tick(2);
        t = cyc;
        for (int i = 0; i < 6; i++) exp_wr.push_back(t + 1 + i);
        pulse_go();
        tick(6);
        t = cyc;
        for (int i = 0; i < 3; i++) exp_wr.push_back(t + 1 + i);
        pulse_go();
        tick(2);
        cmd_arm = 1'b0;
        tick(1);
        check("abort_state", state_o, 0);
        check("abort_arm", arm_o, 0);
        check("abort_wr", fifo_wr_o, 0);
        check("abort_seg_kept", seg_index_o, 1);
        tick(4);
        check("abort_wr_drained", exp_wr.size(), 0);

        // Asynchronous reset in the middle of a gap.
        num_segments = 16'd3;
        segment_samples = 32'd4;
        segment_cycles = 20'd12;
        arm_seq();
        tick(2);
        t = cyc;
        for (int i = 0; i < 4; i++) exp_wr.push_back(t + 1 + i);
        pulse_go();
        tick(6);
        check("gap_state", state_o, 3);
        check("gap_seg_index", seg_index_o, 1);
        #2;
        reset_n = 1'b0;
        cmd_arm = 1'b0;
        #1;
        check("async_rst_state", state_o, 0);
        check("async_rst_arm", arm_o, 0);
        check("async_rst_seg", seg_index_o, 0);
        check("async_rst_misc", {fifo_wr_o, done_o, capture_done_o}, 0);
        exp_wr.delete();
        exp_done.delete();
        @(posedge adc_clk);
        #1;
        reset_n = 1'b1;
        tick(2);

        // ARMED timeout, or no timeout when the feature is not built.
        num_segments = 16'd1;
        segment_samples = 32'd4;
        segment_cycles = 20'd0;
        timeout_cycles = 32'd50;
        cmd_arm = 1'b1;
        t = cyc;
`ifdef SEG_TIMEOUT_EN
        exp_done.push_back(t + 51);
        tick(52);
        check("timeout_flag", timeout_o, 1);
        check("timeout_done", done_o, 1);
        check("timeout_drained", exp_done.size(), 0);
`else
        tick(60);
        check("no_timeout_state", state_o, 1);
        check("no_timeout_flag", timeout_o, 0);
`endif
        release_arm();
        timeout_cycles = 32'd0;

        // Randomized captures against the reference model.
        for (int k = 0; k < 10; k++) begin
            int nr, sr, p;
            bit inj;
            nr  = $urandom_range(0, 4);
            sr  = $urandom_range(0, 8);
            p   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 16);
            inj = 1'($urandom_range(0, 1));
            do_capture(nr, sr, p, $urandom_range(1, 5), 0, inj);
        end

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
